// File: rtl/txll_fsm_pkg.sv
// Shared definitions for the TX link-layer FIFO writer.
//   state_t    : FSM encoding, also exported on txll2dbg[27:26]
//   *_BIT      : flag positions inside the 36-bit TX FIFO word
//   pack_word  : builds one TX FIFO word from data and flags
package txll_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int ABT_BIT = 34;

  localparam int C_MAX_DW_DEF  = 2048;
  localparam int C_TIMEOUT_DEF = 1024;

  function automatic logic [35:0] pack_word(input logic [31:0] data,
                                            input logic        sof,
                                            input logic        eof,
                                            input logic        abt);
    logic [35:0] w;
    w          = '0;
    w[31:0]    = data;
    w[SOF_BIT] = sof;
    w[EOF_BIT] = eof;
    w[ABT_BIT] = abt;
    return w;
  endfunction

endpackage

// File: rtl/txll_fsm_wdog.sv
// Payload idle watchdog.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   clr                : restart the idle count (beat seen or not in DATA)
//   en                 : count this cycle as idle
//   expire             : idle count has reached C_TIMEOUT-1
module txll_fsm_wdog #(
  parameter int C_TIMEOUT = 1024
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(C_TIMEOUT) + 1;

  logic [W-1:0] idle_q;

  // Counter saturates at the expire value so it never wraps back to zero.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      idle_q <= '0;
    end else if (clr) begin
      idle_q <= '0;
    end else if (en && !expire) begin
      idle_q <= idle_q + W'(1);
    end
  end

  assign expire = (idle_q == W'(C_TIMEOUT - 1));

endmodule

// File: rtl/txll_fsm.sv
// Transmit link-layer FIFO writer: frames a FIS header plus txdma payload
// dwords into the 36-bit TX FIFO (sof/eof/abort flags), with backpressure,
// idle-timeout abort and sticky violation flags.
//   sys_clk, sys_rst_n          : clock, synchronous active-low reset
//   port2txll_*  / txll2port_*  : FIS request (hdr, len) and ack/done/err pulses
//   txdma2txll_* / txll2txdma_* : payload dwords in, backpressure out
//   wr_*                        : TX FIFO write side (registered wr_en/wr_di)
//   wr_eof_rdy                  : pulse once the EOF dword has been written
//   txll2dbg                    : {af, full, ovf, fullwr, state, wr_count, cnt}
module txll_fsm
  import txll_fsm_pkg::*;
#(
  parameter int C_MAX_DW  = C_MAX_DW_DEF,
  parameter int C_CNT_W   = 12,
  parameter int C_TIMEOUT = C_TIMEOUT_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               port2txll_req,
  input  logic [31:0]        port2txll_fis_hdr,
  input  logic [C_CNT_W-1:0] port2txll_len,
  output logic               txll2port_ack,
  output logic               txll2port_done,
  output logic               txll2port_err,
  input  logic               txdma2txll_wr_en,
  input  logic [31:0]        txdma2txll_wr_di,
  output logic               txll2txdma_wr_full,
  output logic               wr_clk,
  output logic               wr_en,
  output logic [35:0]        wr_di,
  input  logic               wr_full,
  input  logic               wr_almost_full,
  input  logic [9:0]         wr_count,
  output logic               wr_eof_rdy,
  output logic [31:0]        txll2dbg
);

  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, fullwr_q;
  logic               wr_en_p1, wr_en_d;
  logic [35:0]        wr_di_p1, wr_di_d;
  logic               ack_p1, ack_d;
  logic               done_p1, done_d;
  logic               err_p1, err_d;
  logic               beat;
  logic               expire;

  assign wr_clk = sys_clk;

  // Backpressure tracks the FIFO threshold only while payload is expected.
  assign txll2txdma_wr_full = (state_q == ST_DATA) ? wr_almost_full : 1'b1;
  assign beat = (state_q == ST_DATA) && txdma2txll_wr_en && !wr_almost_full;

  txll_fsm_wdog #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_wdog (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (beat || (state_q != ST_DATA)),
    .en        (state_q == ST_DATA),
    .expire    (expire)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    wr_di_d = wr_di_p1;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (port2txll_req && !wr_almost_full) begin
          if (port2txll_len > C_CNT_W'(C_MAX_DW)) begin
            err_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            wr_di_d = pack_word(port2txll_fis_hdr, 1'b1, (port2txll_len == '0), 1'b0);
            ack_d   = 1'b1;
            cnt_d   = port2txll_len;
            state_d = (port2txll_len == '0) ? ST_DONE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          wr_en_d = 1'b1;
          wr_di_d = pack_word(txdma2txll_wr_di, 1'b0, (cnt_q == C_CNT_W'(1)), 1'b0);
          cnt_d   = cnt_q - C_CNT_W'(1);
          if (cnt_q == C_CNT_W'(1)) state_d = ST_DONE;
        end else if (expire) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!wr_almost_full) begin
          wr_en_d = 1'b1;
          wr_di_d = pack_word(32'h0, 1'b0, 1'b1, 1'b1);
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        // The EOF dword is on wr_en during this state, so the registered
        // done pulse lands one cycle after it.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- output register stage (p1) ----
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fullwr_q <= 1'b0;
      wr_en_p1 <= 1'b0;
      wr_di_p1 <= '0;
      ack_p1   <= 1'b0;
      done_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_q | (txdma2txll_wr_en & txll2txdma_wr_full);
      fullwr_q <= fullwr_q | (wr_en_p1 & wr_full);
      wr_en_p1 <= wr_en_d;
      wr_di_p1 <= wr_di_d;
      ack_p1   <= ack_d;
      done_p1  <= done_d;
      err_p1   <= err_d;
    end
  end

  assign wr_en          = wr_en_p1;
  assign wr_di          = wr_di_p1;
  assign txll2port_ack  = ack_p1;
  assign txll2port_done = done_p1;
  assign txll2port_err  = err_p1;
  assign wr_eof_rdy     = done_p1;

  always_comb begin
    txll2dbg                = '0;
    txll2dbg[31]            = wr_almost_full;
    txll2dbg[30]            = wr_full;
    txll2dbg[29]            = ovf_q;
    txll2dbg[28]            = fullwr_q;
    txll2dbg[27:26]         = state_q;
    txll2dbg[25:16]         = wr_count;
    txll2dbg[C_CNT_W-1:0]   = cnt_q;
  end

endmodule

// File: tb/tb_txll_fsm.sv
module tb_txll_fsm;

  localparam int MAX_DW = 2048;
  localparam int TMO    = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        port2txll_req = 1'b0;
  logic [31:0] port2txll_fis_hdr = '0;
  logic [11:0] port2txll_len = '0;
  logic        txll2port_ack, txll2port_done, txll2port_err;
  logic        txdma2txll_wr_en = 1'b0;
  logic [31:0] txdma2txll_wr_di = '0;
  logic        txll2txdma_wr_full;
  logic        wr_clk, wr_en, wr_eof_rdy;
  logic [35:0] wr_di;
  logic        wr_full = 1'b0;
  logic        wr_almost_full = 1'b0;
  logic [9:0]  wr_count = 10'h155;
  logic [31:0] txll2dbg;

  txll_fsm dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .port2txll_req      (port2txll_req),
    .port2txll_fis_hdr  (port2txll_fis_hdr),
    .port2txll_len      (port2txll_len),
    .txll2port_ack      (txll2port_ack),
    .txll2port_done     (txll2port_done),
    .txll2port_err      (txll2port_err),
    .txdma2txll_wr_en   (txdma2txll_wr_en),
    .txdma2txll_wr_di   (txdma2txll_wr_di),
    .txll2txdma_wr_full (txll2txdma_wr_full),
    .wr_clk             (wr_clk),
    .wr_en              (wr_en),
    .wr_di              (wr_di),
    .wr_full            (wr_full),
    .wr_almost_full     (wr_almost_full),
    .wr_count           (wr_count),
    .wr_eof_rdy         (wr_eof_rdy),
    .txll2dbg           (txll2dbg)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: everything the DUT emits, stamped with the cycle it is visible in.
  logic [35:0] got_q[$];
  int          got_t[$];
  int ack_n, done_n, err_n, eof_n;
  int ack_t, done_t, err_t, eof_t;

  always @(negedge sys_clk) begin
    if (wr_en) begin
      got_q.push_back(wr_di);
      got_t.push_back(cyc);
    end
    if (txll2port_ack)  begin ack_n++;  ack_t  = cyc; end
    if (txll2port_done) begin done_n++; done_t = cyc; end
    if (txll2port_err)  begin err_n++;  err_t  = cyc; end
    if (wr_eof_rdy)     begin eof_n++;  eof_t  = cyc; end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference word layout: {0, abort, eof, sof, data}
  function automatic logic [35:0] mk(input logic [31:0] d, input bit sof, input bit eof, input bit abt);
    return {1'b0, abt, eof, sof, d};
  endfunction

  task automatic clr_mon();
    got_q.delete();
    got_t.delete();
    ack_n = 0; done_n = 0; err_n = 0; eof_n = 0;
    ack_t = -1; done_t = -1; err_t = -1; eof_t = -1;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge sys_clk);
    #1;
  endtask

  // One complete frame. A well-behaved txdma: never presents a beat while
  // backpressure is up. seq selects payload 0x11, 0x22, ...; rnd randomises
  // idle gaps and almost-full; af_after/af_cyc hold almost-full after beat
  // number af_after for af_cyc cycles.
  task automatic do_frame(input string tag, input logic [31:0] hdr, input int len,
                          input int af_after, input int af_cyc, input bit rnd,
                          input bit seq, input bit exp_min);
    logic [35:0] exp_q[$];
    logic [31:0] pay[$];
    logic [31:0] d;
    int idx, guard, af_left, last;
    clr_mon();
    exp_q.push_back(mk(hdr, 1'b1, len == 0, 1'b0));
    for (int i = 0; i < len; i++) begin
      d = seq ? 32'h11 * (i + 1) : $urandom;
      pay.push_back(d);
      exp_q.push_back(mk(d, 1'b0, i == len - 1, 1'b0));
    end
    port2txll_fis_hdr = hdr;
    port2txll_len     = 12'(len);
    port2txll_req     = 1'b1;
    tick();
    port2txll_req = 1'b0;
    idx = 0; guard = 0; af_left = af_cyc;
    while (idx < len && guard < 4 * len + 100) begin
      guard++;
      if (rnd) wr_almost_full = ($urandom_range(3) == 0);
      else if (idx == af_after && af_left > 0) begin
        wr_almost_full = 1'b1;
        af_left--;
      end else wr_almost_full = 1'b0;
      txdma2txll_wr_en = !wr_almost_full && (rnd ? ($urandom_range(2) != 0) : 1'b1);
      txdma2txll_wr_di = pay[idx];
      #1;
      chk({tag, " wr_full"}, txll2txdma_wr_full, wr_almost_full);
      @(posedge sys_clk);
      #1;
      if (txdma2txll_wr_en) idx++;
    end
    txdma2txll_wr_en = 1'b0;
    wr_almost_full   = 1'b0;
    chk({tag, " beats"}, idx, len);
    #1;
    chk({tag, " wr_full end"}, txll2txdma_wr_full, 1'b1);
    guard = 0;
    while (done_n == 0 && guard < 20) begin
      wait_neg();
      guard++;
    end
    chk({tag, " done_n"}, done_n, 1);
    chk({tag, " eof_rdy_n"}, eof_n, 1);
    chk({tag, " eof_rdy_t"}, eof_t, done_t);
    chk({tag, " ack_n"}, ack_n, 1);
    chk({tag, " err_n"}, err_n, 0);
    chk({tag, " nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, $sformatf(" word%0d", i)}, got_q[i], exp_q[i]);
    if (got_q.size() > 0) begin
      last = got_q.size() - 1;
      chk({tag, " ack_t"}, ack_t, got_t[0]);
      chk({tag, " done_t"}, done_t, got_t[last] + 1);
      if (exp_min) chk({tag, " span"}, got_t[last] - got_t[0], len);
    end
    chk({tag, " cnt"}, txll2dbg[11:0], 12'h0);
    chk({tag, " idle"}, txll2dbg[27:26], 2'd0);
    tick();
  endtask

  logic [31:0] d0;
  int guard2;

  initial begin
    clr_mon();
    // ---- reset ----
    repeat (3) tick();
    chk("rst wr_en", wr_en, 1'b0);
    chk("rst wr_di", wr_di, 36'h0);
    chk("rst ack/done/err/eof", {txll2port_ack, txll2port_done, txll2port_err, wr_eof_rdy}, 4'h0);
    chk("rst wr_full", txll2txdma_wr_full, 1'b1);
    chk("rst dbg", txll2dbg, {4'h0, 2'd0, 10'h155, 16'h0});
    sys_rst_n = 1'b1;
    tick();

    // ---- len=0 frame ----
    do_frame("len0", 32'h0000_8027, 0, -1, 0, 1'b0, 1'b0, 1'b1);
    chk("len0 word", got_q.size() > 0 ? got_q[0] : 36'hF_FFFF_FFFF, 36'h3_0000_8027);

    // ---- len=3 back-to-back ----
    do_frame("len3", 32'h0000_0046, 3, -1, 0, 1'b0, 1'b1, 1'b1);
    if (got_q.size() == 4) begin
      chk("len3 flags", {got_q[0][35:32], got_q[1][35:32], got_q[2][35:32], got_q[3][35:32]}, 16'h1002);
      chk("len3 last", got_q[3][31:0], 32'h33);
    end else chk("len3 count", got_q.size(), 4);

    // ---- len=4 with almost-full held 5 cycles mid-payload ----
    do_frame("af", 32'h0000_1234, 4, 2, 5, 1'b0, 1'b0, 1'b0);
    if (got_t.size() == 5) chk("af span", got_t[4] - got_t[0], 4 + 5);

    // ---- idle timeout abort ----
    clr_mon();
    d0 = $urandom;
    port2txll_fis_hdr = 32'hABCD_0046;
    port2txll_len     = 12'd2;
    port2txll_req     = 1'b1;
    tick();
    port2txll_req     = 1'b0;
    txdma2txll_wr_en  = 1'b1;
    txdma2txll_wr_di  = d0;
    tick();
    txdma2txll_wr_en  = 1'b0;
    guard2 = 0;
    while (err_n == 0 && guard2 < TMO + 50) begin
      wait_neg();
      guard2++;
    end
    chk("tmo err_n", err_n, 1);
    chk("tmo done_n", done_n, 0);
    chk("tmo nwr", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("tmo hdr", got_q[0], mk(32'hABCD_0046, 1'b1, 1'b0, 1'b0));
      chk("tmo beat", got_q[1], mk(d0, 1'b0, 1'b0, 1'b0));
      chk("tmo abort", got_q[2], 36'h6_0000_0000);
      chk("tmo err_t", err_t, got_t[2]);
      chk("tmo gap", (got_t[2] - got_t[1] >= TMO) && (got_t[2] - got_t[1] <= TMO + 1), 1'b1);
    end
    chk("tmo idle", txll2dbg[27:26], 2'd0);
    tick();

    // ---- oversize reject ----
    clr_mon();
    port2txll_fis_hdr = 32'h0000_0027;
    port2txll_len     = 12'(MAX_DW + 1);
    port2txll_req     = 1'b1;
    tick();
    port2txll_req     = 1'b0;
    repeat (3) wait_neg();
    chk("rej err_n", err_n, 1);
    chk("rej ack_n", ack_n, 0);
    chk("rej nwr", got_q.size(), 0);
    chk("rej wr_full", txll2txdma_wr_full, 1'b1);

    // ---- random frames ----
    for (int k = 0; k < 4; k++)
      do_frame("rnd", $urandom, $urandom_range(1, 8), -1, 0, 1'b1, 1'b0, 1'b0);

    // ---- reset mid-frame ----
    clr_mon();
    port2txll_fis_hdr = 32'h0000_5555;
    port2txll_len     = 12'd5;
    port2txll_req     = 1'b1;
    tick();
    port2txll_req     = 1'b0;
    wr_full           = 1'b1;  // header is on wr_en now
    txdma2txll_wr_en  = 1'b1;
    txdma2txll_wr_di  = 32'hA1;
    tick();
    wr_full           = 1'b0;
    txdma2txll_wr_di  = 32'hA2;
    tick();
    wr_almost_full    = 1'b1;  // txdma ignores backpressure for one beat
    txdma2txll_wr_di  = 32'hA3;
    tick();
    txdma2txll_wr_en  = 1'b0;
    wr_almost_full    = 1'b0;
    #1;
    chk("pre ovf", txll2dbg[29], 1'b1);
    chk("pre fullwr", txll2dbg[28], 1'b1);
    chk("pre cnt", txll2dbg[11:0], 12'd3);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("mid wr_en", wr_en, 1'b0);
    chk("mid wr_di", wr_di, 36'h0);
    chk("mid pulses", {txll2port_ack, txll2port_done, txll2port_err, wr_eof_rdy}, 4'h0);
    chk("mid wr_full", txll2txdma_wr_full, 1'b1);
    chk("mid dbg", txll2dbg, {4'h0, 2'd0, 10'h155, 16'h0});
    tick();
    do_frame("post", 32'h0000_8027, 0, -1, 0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
